// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port.
// Handshake: a requester holds req[i] and its fields stable until rsp[i]
// pulses for one cycle. The arbiter holds mem_req and mem_* stable until
// mem_ack is seen while the memory request is active, or until it times out.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // requester side
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [BE_W-1:0]   be0;
    logic [BE_W-1:0]   be1;
    logic [1:0]        gnt;
    logic [1:0]        rsp;
    logic              rsp_err;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter view
    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, be0, be1,
        input  mem_ack, mem_rdata,
        output gnt, rsp, rsp_err, rdata, busy,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // requester + memory view
    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, be0, be1,
        output mem_ack, mem_rdata,
        input  gnt, rsp, rsp_err, rdata, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU
// (port 0) and the loader/DMA engine (port 1). The winning request is latched
// and held to memory until acknowledged or timed out; a one-cycle rsp pulse
// then returns the result to the owner.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dmem_arbiter_if.slave        bus,
    output logic [1:0]           dbg_state
);
    localparam int BE_W  = DATA_W / 8;
    // counter only has to reach TIMEOUT-1
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;

    logic              win;
    logic              timeout_hit;

    // timeout fires on the last allowed BUSY cycle when enabled
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // next-state logic: arbitration in IDLE, ack/timeout in BUSY, pulse in RESP
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
        rdata_d     = rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        win         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    // on a tie the port that did not win last time goes first
                    win         = (bus.req == 2'b11) ? ~last_gnt_q : bus.req[1];
                    gnt_d       = win ? 2'b10 : 2'b01;
                    last_gnt_d  = win;
                    mem_we_d    = bus.we[win];
                    mem_addr_d  = win ? bus.addr1  : bus.addr0;
                    mem_wdata_d = win ? bus.wdata1 : bus.wdata0;
                    mem_be_d    = win ? bus.be1    : bus.be0;
                    cnt_d       = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // an ack in the final timeout cycle still completes normally
                if (bus.mem_ack) begin
                    rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                gnt_d     = 2'b00;
                rsp_err_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                gnt_d     = 2'b00;
                rsp_err_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // state and latched request registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            last_gnt_q  <= 1'b1;
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // outputs decoded from registered state so reset drops them at once
    always_comb begin
        bus.gnt       = gnt_q;
        bus.rsp       = (state_q == S_RESP) ? gnt_q : 2'b00;
        bus.rsp_err   = rsp_err_q;
        bus.rdata     = rdata_q;
        bus.busy      = (state_q != S_IDLE);
        bus.mem_req   = (state_q == S_BUSY);
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.mem_be    = mem_be_q;
        dbg_state     = state_q;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: plays both requesters and the memory,
// predicts winner, latency and response from a transaction-level model.
module tb_dmem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] dbg_state;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int                last_win = 1;
    logic [DATA_W-1:0] hold_rd  = '0;
    logic [DATA_W-1:0] exp_q[$];

    // requester fields for the next transaction
    logic              f_we   [2];
    logic [ADDR_W-1:0] f_addr [2];
    logic [DATA_W-1:0] f_wdata[2];
    logic [BE_W-1:0]   f_be   [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 2; i++) begin
            f_we[i]    = 1'($urandom_range(0, 1));
            f_addr[i]  = $urandom;
            f_wdata[i] = $urandom;
            f_be[i]    = BE_W'($urandom_range(1, (1 << BE_W) - 1));
        end
    endtask

    // Issue one transaction from an IDLE negedge and follow it to the next
    // IDLE negedge. ack_delay = index of the BUSY cycle carrying mem_ack.
    task automatic run_txn(input logic [1:0] rq, input int ack_delay,
                           input logic [DATA_W-1:0] ack_data, input bit scramble);
        int                win;
        int                exp_cycles;
        int                busy_n;
        bit                got;
        logic [DATA_W-1:0] exp_rd;
        logic              exp_err;
        logic [1:0]        exp_oh;

        win        = (rq == 2'b11) ? 1 - last_win : (rq[1] ? 1 : 0);
        last_win   = win;
        exp_oh     = (win == 1) ? 2'b10 : 2'b01;
        exp_cycles = (ack_delay < TIMEOUT) ? ack_delay + 1 : TIMEOUT;
        exp_q.delete();

        bus.req    = rq;
        bus.we     = {f_we[1], f_we[0]};
        bus.addr0  = f_addr[0];
        bus.addr1  = f_addr[1];
        bus.wdata0 = f_wdata[0];
        bus.wdata1 = f_wdata[1];
        bus.be0    = f_be[0];
        bus.be1    = f_be[1];

        busy_n = 0;
        got    = 1'b0;
        for (int c = 0; c < TIMEOUT + 6; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.rsp != 2'b00) begin
                got = 1'b1;
                if (exp_q.size() > 0) begin
                    exp_rd  = exp_q.pop_front();
                    exp_err = 1'b0;
                end else begin
                    exp_rd  = '0;
                    exp_err = 1'b1;
                end
                check_eq("busy_cycles", 64'(busy_n), 64'(exp_cycles));
                check_eq("rsp", bus.rsp, exp_oh);
                check_eq("rsp_gnt", bus.gnt, exp_oh);
                check_eq("rsp_err", bus.rsp_err, exp_err);
                check_eq("rdata", bus.rdata, exp_rd);
                check_eq("rsp_mem_req", bus.mem_req, 1'b0);
                check_eq("rsp_busy", bus.busy, 1'b1);
                hold_rd = exp_rd;
                // a late ack landing in RESP must be ignored
                if (busy_n == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = $urandom;
                end
                bus.req = 2'b00;
                break;
            end else if (bus.mem_req) begin
                if (busy_n == 0) begin
                    check_eq("gnt", bus.gnt, exp_oh);
                    check_eq("busy", bus.busy, 1'b1);
                    check_eq("mem_we", bus.mem_we, f_we[win]);
                    check_eq("mem_be", bus.mem_be, f_be[win]);
                end
                check_eq("mem_addr", bus.mem_addr, f_addr[win]);
                check_eq("mem_wdata", bus.mem_wdata, f_wdata[win]);
                if (busy_n == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = ack_data;
                    exp_q.push_back(f_we[win] ? '0 : ack_data);
                end
                if (scramble) begin
                    bus.addr0  = $urandom;
                    bus.addr1  = $urandom;
                    bus.wdata0 = $urandom;
                    bus.wdata1 = $urandom;
                    if ($urandom_range(0, 1) == 1) bus.req = 2'b00;
                end
                busy_n++;
            end else begin
                check_eq("mem_req_active", bus.mem_req, 1'b1);
                break;
            end
        end
        check_eq("rsp_seen", got, 1'b1);

        @(negedge clk);
        bus.mem_ack = 1'b0;
        check_eq("idle_gnt", bus.gnt, 2'b00);
        check_eq("idle_rsp", bus.rsp, 2'b00);
        check_eq("idle_busy", bus.busy, 1'b0);
        check_eq("idle_err", bus.rsp_err, 1'b0);
        check_eq("idle_rdata_hold", bus.rdata, hold_rd);
    endtask

    initial begin
        // reset
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.we        = '0;
        bus.addr0     = '0;
        bus.addr1     = '0;
        bus.wdata0    = '0;
        bus.wdata1    = '0;
        bus.be0       = '0;
        bus.be1       = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #1;
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_gnt", bus.gnt, 2'b00);
        check_eq("rst_rsp", bus.rsp, 2'b00);
        check_eq("rst_err", bus.rsp_err, 1'b0);
        check_eq("rst_rdata", bus.rdata, '0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, '0);
        check_eq("rst_mem_wdata", bus.mem_wdata, '0);
        check_eq("rst_mem_be", bus.mem_be, '0);
        check_eq("rst_mem_we", bus.mem_we, 1'b0);
        check_eq("rst_state", dbg_state, 2'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // single read, port 0, ack in third BUSY cycle
        rand_fields();
        f_we[0]   = 1'b0;
        f_addr[0] = 32'h100;
        run_txn(2'b01, 2, 32'hDEADBEEF, 1'b0);

        // contention, zero-wait memory
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            run_txn(2'b11, 0, $urandom, 1'b0);
        end

        // byte-enabled write from port 1
        rand_fields();
        f_we[1]    = 1'b1;
        f_addr[1]  = 32'h24;
        f_wdata[1] = 32'h0000_00AB;
        f_be[1]    = 4'b0001;
        run_txn(2'b10, 0, 32'h1234_5678, 1'b0);

        // timeout with no ack, then ack arriving only in RESP
        rand_fields();
        f_we[0] = 1'b0;
        run_txn(2'b01, TIMEOUT + 3, 32'h0, 1'b0);
        rand_fields();
        f_we[0] = 1'b0;
        run_txn(2'b01, TIMEOUT, 32'h77, 1'b0);

        // ack on the final timeout cycle wins
        rand_fields();
        f_we[0] = 1'b0;
        run_txn(2'b01, TIMEOUT - 1, 32'h5, 1'b0);

        // reset mid-BUSY
        rand_fields();
        bus.req   = 2'b01;
        bus.we    = {f_we[1], f_we[0]};
        bus.addr0 = f_addr[0];
        @(negedge clk);
        check_eq("pre_rst_mem_req", bus.mem_req, 1'b1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("async_mem_req", bus.mem_req, 1'b0);
        check_eq("async_gnt", bus.gnt, 2'b00);
        check_eq("async_busy", bus.busy, 1'b0);
        check_eq("async_mem_addr", bus.mem_addr, '0);
        bus.req  = 2'b00;
        last_win = 1;
        hold_rd  = '0;
        repeat (2) begin
            @(negedge clk);
            check_eq("in_rst_rsp", bus.rsp, 2'b00);
        end
        reset_n = 1'b1;
        rand_fields();
        run_txn(2'b10, 1, $urandom, 1'b0);
        rand_fields();
        run_txn(2'b11, 0, $urandom, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int d;
            rand_fields();
            if ($urandom_range(0, 3) == 0) d = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            else                           d = $urandom_range(0, 4);
            run_txn(2'($urandom_range(1, 3)), d, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
